reg_file_param: RTL and testbench

- Parametrised multi-port register file; successor to the single fixed-width load register.
- Generalised in width and depth, with 2 read ports and 1 write port.
- Adds a hardwired-zero register option and a sequenced bulk-clear engine with a busy flag.
- Sits in the decode stage of the single-cycle RISC-V datapath. Feeds rs1/rs2 operands and takes the writeback result.

---
 rtl/reg_file_param.sv | 83 ++++++++
 tb/tb_reg_file_param.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_param.sv
// Parametrised register file: 2 combinational read ports, 1 write port, sequenced bulk clear.
// Optional same-cycle write-to-read forwarding when REGFILE_BYPASS_EN is defined.
module reg_file_param #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [WIDTH-1:0]  rdata1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [WIDTH-1:0]  rdata2,
  input  logic              clr_req,
  output logic              busy
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic              wr_ok;

  // An address is usable when it is in range and is not the hardwired zero register.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return (32'(a) < DEPTH) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign wr_ok = we && !busy && addr_ok(waddr);

  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (addr_ok(raddr1)) rdata1 = mem[raddr1];
    if (addr_ok(raddr2)) rdata2 = mem[raddr2];
`ifdef REGFILE_BYPASS_EN
    // wr_ok already implies a valid, writable address, so the zero/range rules hold.
    if (wr_ok && (raddr1 == waddr)) rdata1 = wdata;
    if (wr_ok && (raddr2 == waddr)) rdata2 = wdata;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      cnt   <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_ok) mem[waddr] <= wdata;
      case (state)
        IDLE: begin
          if (clr_req) begin
            state <= CLEAR;
            busy  <= 1'b1;
            cnt   <= '0;
          end
        end
        CLEAR: begin
          mem[cnt] <= '0;
          if (cnt == ADDR_W'(DEPTH - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + ADDR_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_file_param.sv
// Directed bench for reg_file_param: default instance, a ZERO_REG=0 instance and a DEPTH=24 instance
// share the same stimulus.
module tb_reg_file_param;

  logic        clk = 1'b0;
  logic        rst, we, clr_req;
  logic [4:0]  waddr, raddr1, raddr2;
  logic [31:0] wdata;
  logic [31:0] rdata1, rdata2, rdata1_z, rdata2_z, rdata1_s, rdata2_s;
  logic        busy, busy_z, busy_s;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  reg_file_param dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .rdata1(rdata1), .raddr2(raddr2), .rdata2(rdata2),
    .clr_req(clr_req), .busy(busy));

  reg_file_param #(.ZERO_REG(0)) dut_z (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .rdata1(rdata1_z), .raddr2(raddr2), .rdata2(rdata2_z),
    .clr_req(clr_req), .busy(busy_z));

  reg_file_param #(.DEPTH(24)) dut_s (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .rdata1(rdata1_s), .raddr2(raddr2), .rdata2(rdata2_s),
    .clr_req(clr_req), .busy(busy_s));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; we = 1'b1; waddr = 5'd4; wdata = 32'h44; clr_req = 1'b1;
    raddr1 = '0; raddr2 = '0;
    tick();
    tick();
    rst = 1'b0; we = 1'b0; clr_req = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else n_pass++;
    for (int a = 0; a < 32; a++) begin
      raddr1 = 5'(a); raddr2 = 5'(31 - a);
      #1;
      n_checks++;
      if (rdata1 !== 32'h0 || rdata2 !== 32'h0)
        $display("FAIL reset_read a=%0d got %h/%h exp 0/0", a, rdata1, rdata2);
      else n_pass++;
    end
  endtask

  task automatic test_write_read();
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
    tick();
    we = 1'b0; raddr1 = 5'd5; raddr2 = 5'd5;
    #1;
    n_checks++;
    if (rdata1 !== 32'hDEADBEEF || rdata2 !== 32'hDEADBEEF)
      $display("FAIL write_read got %h/%h exp deadbeef", rdata1, rdata2);
    else n_pass++;
    raddr2 = 5'd6;
    #1;
    n_checks++;
    if (rdata2 !== 32'h0) $display("FAIL neighbour_reg6 got %h exp 0", rdata2); else n_pass++;
  endtask

  task automatic test_zero_reg();
    we = 1'b1; waddr = 5'd0; wdata = 32'h12345678; raddr1 = 5'd0;
    tick();
    we = 1'b0;
    #1;
    n_checks++;
    if (rdata1 !== 32'h0) $display("FAIL zero_reg got %h exp 0", rdata1); else n_pass++;
    n_checks++;
    if (rdata1_z !== 32'h12345678)
      $display("FAIL zero_reg_off got %h exp 12345678", rdata1_z);
    else n_pass++;
  endtask

  task automatic test_same_cycle();
    logic [31:0] exp;
    we = 1'b1; waddr = 5'd7; wdata = 32'h1;
    tick();
    wdata = 32'hA5A5A5A5; raddr1 = 5'd7;
    #1;
`ifdef REGFILE_BYPASS_EN
    exp = 32'hA5A5A5A5;
`else
    exp = 32'h1;
`endif
    n_checks++;
    if (rdata1 !== exp) $display("FAIL same_cycle got %h exp %h", rdata1, exp); else n_pass++;
    tick();
    we = 1'b0;
    #1;
    n_checks++;
    if (rdata1 !== 32'hA5A5A5A5) $display("FAIL after_write got %h exp a5a5a5a5", rdata1); else n_pass++;
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF0000; raddr1 = 5'd0;
    #1;
    n_checks++;
    if (rdata1 !== 32'h0) $display("FAIL same_cycle_zero got %h exp 0", rdata1); else n_pass++;
    we = 1'b0;
  endtask

  task automatic test_out_of_range();
    we = 1'b1; waddr = 5'd30; wdata = 32'hCAFE;
    tick();
    waddr = 5'd23; wdata = 32'h2323;
    tick();
    we = 1'b0; raddr1 = 5'd30; raddr2 = 5'd23;
    #1;
    n_checks++;
    if (rdata1_s !== 32'h0) $display("FAIL oor_read got %h exp 0", rdata1_s); else n_pass++;
    n_checks++;
    if (rdata1 !== 32'hCAFE) $display("FAIL reg30 got %h exp cafe", rdata1); else n_pass++;
    n_checks++;
    if (rdata2_s !== 32'h2323) $display("FAIL last_reg got %h exp 2323", rdata2_s); else n_pass++;
  endtask

  task automatic test_clear();
    int busy_cnt;
    logic [31:0] e10, e3;
    for (int i = 1; i < 32; i++) begin
      we = 1'b1; waddr = 5'(i); wdata = 32'(i);
      tick();
    end
    we = 1'b0; raddr1 = 5'd10; raddr2 = 5'd3; clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    busy_cnt = 0;
    for (int k = 1; k <= 32; k++) begin
      if (k == 20) begin we = 1'b1; waddr = 5'd3; wdata = 32'hFF; end
      if (k == 15) clr_req = 1'b1;
      #1;
      if (busy === 1'b1) busy_cnt++;
      e10 = (k <= 11) ? 32'd10 : 32'd0;
      e3  = (k <= 4)  ? 32'd3  : 32'd0;
      n_checks++;
      if (rdata1 !== e10 || rdata2 !== e3)
        $display("FAIL clear_progress k=%0d got %h/%h exp %h/%h", k, rdata1, rdata2, e10, e3);
      else n_pass++;
      tick();
      we = 1'b0; clr_req = 1'b0;
    end
    #1;
    n_checks++;
    if (busy_cnt !== 32) $display("FAIL busy_len got %0d exp 32", busy_cnt); else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL busy_fall got %b exp 0", busy); else n_pass++;
    for (int a = 0; a < 32; a++) begin
      raddr1 = 5'(a); raddr2 = 5'(a);
      #1;
      n_checks++;
      if (rdata1 !== 32'h0 || rdata2_z !== 32'h0)
        $display("FAIL cleared a=%0d got %h/%h exp 0/0", a, rdata1, rdata2_z);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    int guard;
    we = 1'b1; waddr = 5'd12; wdata = 32'h77; clr_req = 1'b1; raddr1 = 5'd12;
    tick();
    we = 1'b0; clr_req = 1'b0;
    #1;
    n_checks++;
    if (rdata1 !== 32'h77 || busy !== 1'b1)
      $display("FAIL wr_and_clr got %h busy %b exp 77 busy 1", rdata1, busy);
    else n_pass++;
    repeat (12) tick();
    n_checks++;
    if (rdata1 !== 32'h77) $display("FAIL wr_and_clr_c13 got %h exp 77", rdata1); else n_pass++;
    tick();
    n_checks++;
    if (rdata1 !== 32'h0) $display("FAIL wr_and_clr_c14 got %h exp 0", rdata1); else n_pass++;
    guard = 0;
    while (busy === 1'b1 && guard < 40) begin tick(); guard++; end
    n_checks++;
    if (busy !== 1'b0) $display("FAIL b2b_timeout busy %b exp 0", busy); else n_pass++;
  endtask

  task automatic test_reset_mid_clear();
    int bad;
    we = 1'b1; waddr = 5'd20; wdata = 32'h20;
    tick();
    waddr = 5'd31; wdata = 32'h31;
    tick();
    we = 1'b0; clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL mid_clear_busy got %b exp 0", busy); else n_pass++;
    bad = 0;
    for (int a = 0; a < 32; a++) begin
      raddr1 = 5'(a);
      #1;
      if (rdata1 !== 32'h0) bad++;
    end
    n_checks++;
    if (bad !== 0) $display("FAIL mid_clear_regs got %0d nonzero exp 0", bad); else n_pass++;
    we = 1'b1; waddr = 5'd9; wdata = 32'h55;
    tick();
    we = 1'b0; raddr1 = 5'd9;
    #1;
    n_checks++;
    if (rdata1 !== 32'h55) $display("FAIL post_reset_write got %h exp 55", rdata1); else n_pass++;
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; clr_req = 1'b0;
    waddr = '0; wdata = '0; raddr1 = '0; raddr2 = '0;
    test_reset();
    test_write_read();
    test_zero_reg();
    test_same_cycle();
    test_out_of_range();
    test_clear();
    test_back_to_back();
    test_reset_mid_clear();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
